// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the datapath/memory it steers.
// The master modport is the sequencer side; the slave modport is the datapath side.
interface control_sequencer_if #(
    parameter int OFF_W    = 4,
    parameter int ALU_OP_W = 3
) ();
    logic [OFF_W+3:0]    instr;
    logic                zf;
    logic                mem_ready;
    logic [2:0]          state;
    logic                pc_we;
    logic                pc_jmp_sel;
    logic [OFF_W-1:0]    pc_offset;
    logic [OFF_W-1:0]    addr_offset;
    logic                addr_sel;
    logic                mem_sel;
    logic                mem_we;
    logic                mem_req;
    logic [ALU_OP_W-1:0] alu_opcode;
    logic                alu_we;
    logic                zf_we;
    logic                ir_we;
    logic                a_we;
    logic                a_sel;
    logic                b_we;
    logic                halt;
    logic                fault;

    modport master (
        input  instr, zf, mem_ready,
        output state, pc_we, pc_jmp_sel, pc_offset, addr_offset, addr_sel, mem_sel,
               mem_we, mem_req, alu_opcode, alu_we, zf_we, ir_we, a_we, a_sel, b_we,
               halt, fault
    );

    modport slave (
        output instr, zf, mem_ready,
        input  state, pc_we, pc_jmp_sel, pc_offset, addr_offset, addr_sel, mem_sel,
               mem_we, mem_req, alu_opcode, alu_we, zf_we, ir_we, a_we, a_sel, b_we,
               halt, fault
    );
endinterface

// File: rtl/control_sequencer.sv
// Multi-cycle CPU control sequencer: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK/IDLE/HALT
// with a memory wait watchdog that halts with a fault on timeout.
module control_sequencer #(
    parameter int OFF_W    = 4,
    parameter int WAIT_MAX = 15,
    parameter int ALU_OP_W = 3
) (
    input logic                 clk,
    input logic                 reset,
    control_sequencer_if.master bus
);
    localparam int INSTR_W = OFF_W + 4;
    localparam int CNT_W   = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        FETCH      = 3'b000,
        DECODE     = 3'b001,
        EXECUTE    = 3'b010,
        MEMORY     = 3'b011,
        WRITEBACK  = 3'b100,
        HALT_STATE = 3'b101,
        IDLE       = 3'b110
    } state_t;

    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_ADD   = 3'b001,
        OP_SUB   = 3'b010,
        OP_LOAD  = 3'b011,
        OP_STORE = 3'b100,
        OP_JMP   = 3'b101,
        OP_JZ    = 3'b110,
        OP_HALT  = 3'b111
    } opcode_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt;
    logic             fault_q, fault_d;

    logic [2:0]       opcode_bits;
    opcode_t          opcode;
    logic             reg_sel;
    logic [OFF_W-1:0] offset;
    logic             wait_hit;
    logic             waiting;

    assign opcode_bits = bus.instr[INSTR_W-1 -: 3];
    assign opcode      = opcode_t'(opcode_bits);
    assign reg_sel     = bus.instr[OFF_W];
    assign offset      = bus.instr[OFF_W-1:0];
    assign wait_hit    = (wait_cnt == CNT_W'(WAIT_MAX));
    // Remaining in FETCH/MEMORY only ever happens while mem_ready is low.
    assign waiting     = (state_d == state_q) && ((state_q == FETCH) || (state_q == MEMORY));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= FETCH;
            wait_cnt <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            fault_q  <= fault_d;
            wait_cnt <= waiting ? wait_cnt + 1'b1 : '0;
        end
    end

    // NOTE: every output and next-state signal gets a default first, so no
    // path through the case statement can infer a latch.
    always_comb begin
        state_d         = state_q;
        fault_d         = fault_q;
        bus.pc_we       = 1'b0;
        bus.pc_jmp_sel  = 1'b0;
        bus.pc_offset   = '0;
        bus.addr_offset = '0;
        bus.addr_sel    = 1'b0;
        bus.mem_sel     = 1'b0;
        bus.mem_we      = 1'b0;
        bus.mem_req     = 1'b0;
        bus.alu_opcode  = '0;
        bus.alu_we      = 1'b0;
        bus.zf_we       = 1'b0;
        bus.ir_we       = 1'b0;
        bus.a_we        = 1'b0;
        bus.a_sel       = 1'b0;
        bus.b_we        = 1'b0;
        bus.halt        = 1'b0;

        case (state_q)
            FETCH: begin
                bus.mem_req = 1'b1;
                bus.ir_we   = bus.mem_ready;
                if (bus.mem_ready) begin
                    bus.pc_we = 1'b1;
                    state_d   = DECODE;
                end else if (wait_hit) begin
                    state_d = HALT_STATE;
                    fault_d = 1'b1;
                end
            end
            DECODE: state_d = EXECUTE;
            EXECUTE: begin
                case (opcode)
                    OP_ADD, OP_SUB: begin
                        bus.alu_opcode = ALU_OP_W'(opcode_bits);
                        bus.alu_we     = 1'b1;
                        bus.zf_we      = 1'b1;
                        state_d        = WRITEBACK;
                    end
                    OP_LOAD, OP_STORE: state_d = MEMORY;
                    OP_JMP: begin
                        bus.pc_we      = 1'b1;
                        bus.pc_jmp_sel = 1'b1;
                        bus.pc_offset  = offset;
                        state_d        = IDLE;
                    end
                    OP_JZ: begin
                        bus.pc_we      = bus.zf;
                        bus.pc_jmp_sel = bus.zf;
                        bus.pc_offset  = bus.zf ? offset : '0;
                        state_d        = IDLE;
                    end
                    OP_HALT: state_d = HALT_STATE;
                    default: state_d = IDLE;
                endcase
            end
            MEMORY: begin
                bus.addr_sel    = 1'b1;
                bus.addr_offset = offset;
                bus.mem_req     = 1'b1;
                if (opcode == OP_STORE) begin
                    // A reset cycle must never let an interrupted store write.
                    bus.mem_we  = ~reset;
                    bus.mem_sel = reg_sel;
                end
                if (bus.mem_ready) begin
                    state_d = (opcode == OP_LOAD) ? WRITEBACK : IDLE;
                end else if (wait_hit) begin
                    state_d = HALT_STATE;
                    fault_d = 1'b1;
                end
            end
            WRITEBACK: begin
                if (opcode == OP_LOAD) begin
                    bus.a_we = ~reg_sel;
                    bus.b_we = reg_sel;
                end else if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                    bus.a_we  = 1'b1;
                    bus.a_sel = 1'b1;
                end
                state_d = IDLE;
            end
            IDLE:       state_d = FETCH;
            HALT_STATE: bus.halt = 1'b1;
            default:    state_d = FETCH;
        endcase
    end

    assign bus.state = state_q;
    assign bus.fault = fault_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: per-cycle expected output vectors are queued
// as stimulus is driven and compared against the DUT on the falling edge.
module tb_control_sequencer;
    localparam int OFF_W    = 4;
    localparam int ALU_OP_W = 3;
    localparam int WAIT_MAX = 15;

    localparam logic [2:0] S_F = 3'b000, S_D = 3'b001, S_E = 3'b010, S_M = 3'b011,
                           S_W = 3'b100, S_H = 3'b101, S_I = 3'b110;

    typedef struct packed {
        logic [2:0] state;
        logic       pc_we;
        logic       pc_jmp_sel;
        logic [3:0] pc_offset;
        logic [3:0] addr_offset;
        logic       addr_sel;
        logic       mem_sel;
        logic       mem_we;
        logic       mem_req;
        logic [2:0] alu_opcode;
        logic       alu_we;
        logic       zf_we;
        logic       ir_we;
        logic       a_we;
        logic       a_sel;
        logic       b_we;
        logic       halt;
        logic       fault;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    control_sequencer_if #(.OFF_W(OFF_W), .ALU_OP_W(ALU_OP_W)) bus ();

    control_sequencer #(.OFF_W(OFF_W), .WAIT_MAX(WAIT_MAX), .ALU_OP_W(ALU_OP_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    vec_t  exp_q[$];
    string tag_q[$];
    int    tests = 0;
    int    fails = 0;

    function automatic vec_t observed();
        vec_t r;
        r.state       = bus.state;
        r.pc_we       = bus.pc_we;
        r.pc_jmp_sel  = bus.pc_jmp_sel;
        r.pc_offset   = bus.pc_offset;
        r.addr_offset = bus.addr_offset;
        r.addr_sel    = bus.addr_sel;
        r.mem_sel     = bus.mem_sel;
        r.mem_we      = bus.mem_we;
        r.mem_req     = bus.mem_req;
        r.alu_opcode  = bus.alu_opcode;
        r.alu_we      = bus.alu_we;
        r.zf_we       = bus.zf_we;
        r.ir_we       = bus.ir_we;
        r.a_we        = bus.a_we;
        r.a_sel       = bus.a_sel;
        r.b_we        = bus.b_we;
        r.halt        = bus.halt;
        r.fault       = bus.fault;
        return r;
    endfunction

    function automatic vec_t st(input logic [2:0] s);
        vec_t r = '0;
        r.state = s;
        return r;
    endfunction

    function automatic vec_t fetch_v(input logic mr);
        vec_t r = st(S_F);
        r.mem_req = 1'b1;
        r.ir_we   = mr;
        r.pc_we   = mr;
        return r;
    endfunction

    function automatic vec_t mem_v(input logic [3:0] off, input logic we, input logic sel);
        vec_t r = st(S_M);
        r.addr_sel    = 1'b1;
        r.addr_offset = off;
        r.mem_req     = 1'b1;
        r.mem_we      = we;
        r.mem_sel     = sel;
        return r;
    endfunction

    function automatic vec_t halt_v(input logic f);
        vec_t r = st(S_H);
        r.halt  = 1'b1;
        r.fault = f;
        return r;
    endfunction

    // One clock cycle: queue the expectation, compare mid-cycle, advance past the edge.
    task automatic cyc(input string tag, input vec_t e);
        vec_t  ex, ob;
        string t;
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(negedge clk);
        ex = exp_q.pop_front();
        t  = tag_q.pop_front();
        ob = observed();
        tests++;
        assert (ob === ex) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", t, ob, ex);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic front(input string tag, input logic [7:0] ins);
        bus.instr     = ins;
        bus.mem_ready = 1'b1;
        cyc({tag, "_fetch"}, fetch_v(1'b1));
        cyc({tag, "_decode"}, st(S_D));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t e;
        bus.instr     = '0;
        bus.zf        = 1'b0;
        bus.mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        cyc("reset_fetch", fetch_v(1'b0));
        reset = 1'b0;

        front("nop", 8'h00);
        cyc("nop_exec", st(S_E));
        cyc("nop_idle", st(S_I));

        front("add", 8'h20);
        e = st(S_E); e.alu_opcode = 3'b001; e.alu_we = 1'b1; e.zf_we = 1'b1;
        cyc("add_exec", e);
        e = st(S_W); e.a_we = 1'b1; e.a_sel = 1'b1;
        cyc("add_wb", e);
        cyc("add_idle", st(S_I));

        front("sub", 8'h40);
        e = st(S_E); e.alu_opcode = 3'b010; e.alu_we = 1'b1; e.zf_we = 1'b1;
        cyc("sub_exec", e);
        e = st(S_W); e.a_we = 1'b1; e.a_sel = 1'b1;
        cyc("sub_wb", e);
        cyc("sub_idle", st(S_I));

        front("load_a15", 8'h6F);
        cyc("load_a15_exec", st(S_E));
        cyc("load_a15_mem", mem_v(4'hF, 1'b0, 1'b0));
        e = st(S_W); e.a_we = 1'b1;
        cyc("load_a15_wb", e);
        cyc("load_a15_idle", st(S_I));

        front("load_b2", 8'h72);
        cyc("load_b2_exec", st(S_E));
        cyc("load_b2_mem", mem_v(4'h2, 1'b0, 1'b0));
        e = st(S_W); e.b_we = 1'b1;
        cyc("load_b2_wb", e);
        cyc("load_b2_idle", st(S_I));

        front("store_b3", 8'h93);
        cyc("store_b3_exec", st(S_E));
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) cyc("store_b3_mem_wait", mem_v(4'h3, 1'b1, 1'b1));
        bus.mem_ready = 1'b1;
        cyc("store_b3_mem_done", mem_v(4'h3, 1'b1, 1'b1));
        cyc("store_b3_idle", st(S_I));

        front("jmp9", 8'hA9);
        e = st(S_E); e.pc_we = 1'b1; e.pc_jmp_sel = 1'b1; e.pc_offset = 4'h9;
        cyc("jmp9_exec", e);
        cyc("jmp9_idle", st(S_I));

        front("jz_nz", 8'hC5);
        cyc("jz_zf0_exec", st(S_E));
        cyc("jz_zf0_idle", st(S_I));

        bus.zf = 1'b1;
        front("jz_z", 8'hC5);
        e = st(S_E); e.pc_we = 1'b1; e.pc_jmp_sel = 1'b1; e.pc_offset = 4'h5;
        cyc("jz_zf1_exec", e);
        cyc("jz_zf1_idle", st(S_I));
        bus.zf = 1'b0;

        // A jump sitting on instr during FETCH/DECODE must not leak into outputs.
        front("early_instr", 8'hAF);
        bus.instr = 8'h00;
        cyc("early_instr_exec", st(S_E));
        cyc("early_instr_idle", st(S_I));

        front("halt_op", 8'hE0);
        cyc("halt_op_exec", st(S_E));
        cyc("halt_op_state", halt_v(1'b0));
        bus.mem_ready = 1'b0;
        cyc("halt_op_absorb", halt_v(1'b0));
        reset = 1'b1;
        cyc("halt_op_in_reset", halt_v(1'b0));
        reset = 1'b0;

        // Reset in the middle of a stalled store, then prove the wait counter restarted.
        front("store_rst", 8'h84);
        cyc("store_rst_exec", st(S_E));
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 2; i++) cyc("store_rst_mem_wait", mem_v(4'h4, 1'b1, 1'b0));
        reset = 1'b1;
        cyc("store_rst_in_reset", mem_v(4'h4, 1'b0, 1'b0));
        reset = 1'b0;
        for (int i = 0; i < 16; i++) cyc("fetch_timeout_wait", fetch_v(1'b0));
        bus.mem_ready = 1'b1;
        cyc("fetch_timeout_halt", halt_v(1'b1));
        cyc("fetch_timeout_absorb", halt_v(1'b1));
        reset = 1'b1;
        cyc("fault_in_reset", halt_v(1'b1));
        reset = 1'b0;

        // mem_ready on the last permitted cycle wins over the timeout.
        bus.mem_ready = 1'b0;
        bus.instr     = 8'h00;
        for (int i = 0; i < 15; i++) cyc("fetch_edge_wait", fetch_v(1'b0));
        bus.mem_ready = 1'b1;
        cyc("fetch_edge_ready", fetch_v(1'b1));
        cyc("fetch_edge_decode", st(S_D));
        cyc("fetch_edge_exec", st(S_E));
        cyc("fetch_edge_idle", st(S_I));

        front("load_timeout", 8'h61);
        cyc("load_timeout_exec", st(S_E));
        bus.mem_ready = 1'b0;
        for (int i = 0; i < 16; i++) cyc("load_timeout_mem", mem_v(4'h1, 1'b0, 1'b0));
        cyc("load_timeout_halt", halt_v(1'b1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
